// File: rtl/freq_meas_ctrl_if.sv
// Handshake and status bundle for freq_meas_ctrl: request/mode inputs, measured input pin,
// busy/result status outputs.
interface freq_meas_ctrl_if #(
    parameter int unsigned RES_W = 14
);
    logic             sig_source;
    logic             start;
    logic             cont;
    logic             busy;
    logic             result_valid;
    logic [RES_W-1:0] sig_Hz;
    logic             timeout;
    logic             saturated;

    modport master (
        output sig_source, start, cont,
        input  busy, result_valid, sig_Hz, timeout, saturated
    );

    modport slave (
        input  sig_source, start, cont,
        output busy, result_valid, sig_Hz, timeout, saturated
    );
endinterface

// File: rtl/freq_meas_ctrl.sv
// Frequency measurement sequencer: synchronises sig_source, times PERIODS input periods,
// and divides CLK_HZ*PERIODS by the tick count with a serial restoring divider.
module freq_meas_ctrl #(
    parameter int unsigned CLK_HZ  = 100000,
    parameter int unsigned PERIODS = 1,
    parameter int unsigned CNT_W   = 17,
    parameter int unsigned NUM_W   = 24,
    parameter int unsigned RES_W   = 14
) (
    input  logic            clk_100kHz,
    input  logic            rst_n,
    freq_meas_ctrl_if.slave bus
);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_MEAS, S_DIV, S_DONE} state_t;

    localparam logic [NUM_W-1:0] NUM       = NUM_W'(CLK_HZ * PERIODS);
    localparam logic [CNT_W-1:0] CNT_LAST  = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam int unsigned      DIV_W     = $clog2(NUM_W);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(NUM_W - 1);
    localparam logic [3:0]       ECNT_LAST = 4'(PERIODS - 1);

    state_t           state_q, state_d;
    logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ticks_q, ticks_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [3:0]       ecnt_q, ecnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [NUM_W-1:0] quo_q, quo_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [RES_W-1:0] sig_hz_q, sig_hz_d;
    logic             timeout_q, timeout_d;
    logic             saturated_q, saturated_d;

    logic             sig_edge;
    logic [CNT_W:0]   rem_shift;
    logic             rem_ge;
    logic [NUM_W-1:0] quo_next;

    always_comb begin
        s1_d = bus.sig_source;
        s2_d = s1_q;
        s3_d = s2_q;
        sig_edge = s2_q & ~s3_q;

        // quo_q starts as the numerator and is shifted out MSB-first as quotient bits shift in
        rem_shift = {rem_q, quo_q[NUM_W-1]};
        rem_ge    = rem_shift >= {1'b0, ticks_q};
        quo_next  = {quo_q[NUM_W-2:0], rem_ge};

        state_d     = state_q;
        cnt_d       = cnt_q;
        ticks_d     = ticks_q;
        rem_d       = rem_q;
        ecnt_d      = ecnt_q;
        div_cnt_d   = div_cnt_q;
        quo_d       = quo_q;
        sig_hz_d    = sig_hz_q;
        timeout_d   = timeout_q;
        saturated_d = saturated_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.start) state_d = S_ARM;
            end
            S_ARM: begin
                cnt_d = cnt_q + 1'b1;
                if (sig_edge) begin
                    state_d = S_MEAS;
                    cnt_d   = '0;
                    ecnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_DONE;
                    timeout_d   = 1'b1;
                    sig_hz_d    = '0;
                    saturated_d = 1'b0;
                end
            end
            S_MEAS: begin
                cnt_d = cnt_q + 1'b1;
                if (sig_edge && ecnt_q == ECNT_LAST) begin
                    state_d   = S_DIV;
                    ticks_d   = cnt_q + 1'b1;
                    rem_d     = '0;
                    quo_d     = NUM;
                    div_cnt_d = '0;
                end else begin
                    if (sig_edge) ecnt_d = ecnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d     = S_DONE;
                        timeout_d   = 1'b1;
                        sig_hz_d    = '0;
                        saturated_d = 1'b0;
                    end
                end
            end
            S_DIV: begin
                rem_d     = rem_ge ? (rem_shift[CNT_W-1:0] - ticks_q) : rem_shift[CNT_W-1:0];
                quo_d     = quo_next;
                div_cnt_d = div_cnt_q + 1'b1;
                if (div_cnt_q == DIV_LAST) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b0;
                    if (|quo_next[NUM_W-1:RES_W]) begin
                        sig_hz_d    = '1;
                        saturated_d = 1'b1;
                    end else begin
                        sig_hz_d    = quo_next[RES_W-1:0];
                        saturated_d = 1'b0;
                    end
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = bus.cont ? S_ARM : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_100kHz) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            cnt_q       <= '0;
            ticks_q     <= '0;
            rem_q       <= '0;
            ecnt_q      <= '0;
            div_cnt_q   <= '0;
            quo_q       <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            sig_hz_q    <= '0;
            timeout_q   <= 1'b0;
            saturated_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            cnt_q       <= cnt_d;
            ticks_q     <= ticks_d;
            rem_q       <= rem_d;
            ecnt_q      <= ecnt_d;
            div_cnt_q   <= div_cnt_d;
            quo_q       <= quo_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            sig_hz_q    <= sig_hz_d;
            timeout_q   <= timeout_d;
            saturated_q <= saturated_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.result_valid = valid_q;
    assign bus.sig_Hz       = sig_hz_q;
    assign bus.timeout      = timeout_q;
    assign bus.saturated    = saturated_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Directed bench for freq_meas_ctrl: one PERIODS=1 instance with a short timeout (CNT_W=10)
// and one PERIODS=4 instance with default widths, sharing clock, reset and input signal.
module tb_freq_meas_ctrl;
    localparam int unsigned NUM_W = 24;
    localparam int unsigned RES_W = 14;
    localparam int unsigned TMO1  = 1023;

    logic        clk_100kHz = 1'b0;
    logic        rst_n      = 1'b0;
    logic        sig        = 1'b0;
    int unsigned cyc        = 0;
    int unsigned gen_period = 0;
    int unsigned gen_prev   = 0;
    int unsigned phase      = 0;
    int unsigned rise_cyc   = 0;
    int unsigned errors     = 0;
    int unsigned checks     = 0;

    freq_meas_ctrl_if #(.RES_W(RES_W)) bus1 ();
    freq_meas_ctrl_if #(.RES_W(RES_W)) bus4 ();
    assign bus1.sig_source = sig;
    assign bus4.sig_source = sig;

    freq_meas_ctrl #(.CLK_HZ(100000), .PERIODS(1), .CNT_W(10), .NUM_W(NUM_W), .RES_W(RES_W)) u_dut1 (
        .clk_100kHz (clk_100kHz),
        .rst_n      (rst_n),
        .bus        (bus1)
    );

    freq_meas_ctrl #(.CLK_HZ(100000), .PERIODS(4), .CNT_W(17), .NUM_W(NUM_W), .RES_W(RES_W)) u_dut4 (
        .clk_100kHz (clk_100kHz),
        .rst_n      (rst_n),
        .bus        (bus4)
    );

    always #5 clk_100kHz = ~clk_100kHz;

    // Square-wave source; the rising edge is driven 1 time unit after posedge number rise_cyc.
    always @(posedge clk_100kHz) begin
        cyc = cyc + 1;
        #1;
        if (gen_period != gen_prev) begin
            gen_prev = gen_period;
            phase    = 0;
        end
        if (gen_period == 0) begin
            sig = 1'b0;
        end else begin
            if (phase == 0) begin
                sig      = 1'b1;
                rise_cyc = cyc;
            end else if (phase == gen_period / 2) begin
                sig = 1'b0;
            end
            phase = (phase + 1 == gen_period) ? 0 : phase + 1;
        end
    end

    task automatic pulse_start(input bit four, output int unsigned s);
        @(posedge clk_100kHz); #1;
        if (four) bus4.start = 1'b1;
        else      bus1.start = 1'b1;
        @(posedge clk_100kHz); #1;
        bus1.start = 1'b0;
        bus4.start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_rv(input bit four, input int unsigned limit,
                           output bit found, output int unsigned at, output bit busy_low);
        found = 1'b0; at = 0; busy_low = 1'b0;
        for (int unsigned i = 0; i < limit; i++) begin
            @(negedge clk_100kHz);
            if ((four ? bus4.busy : bus1.busy) !== 1'b1) busy_low = 1'b1;
            if ((four ? bus4.result_valid : bus1.result_valid) === 1'b1) begin
                found = 1'b1;
                at    = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk_100kHz);
        checks++;
        if ({bus1.busy, bus1.result_valid, bus1.timeout, bus1.saturated, bus1.sig_Hz} !== '0) begin
            errors++;
            $display("FAIL reset_dut1: got busy=%b rv=%b tmo=%b sat=%b hz=%0d expected all 0",
                     bus1.busy, bus1.result_valid, bus1.timeout, bus1.saturated, bus1.sig_Hz);
        end
        checks++;
        if ({bus4.busy, bus4.result_valid, bus4.timeout, bus4.saturated, bus4.sig_Hz} !== '0) begin
            errors++;
            $display("FAIL reset_dut4: got busy=%b rv=%b tmo=%b sat=%b hz=%0d expected all 0",
                     bus4.busy, bus4.result_valid, bus4.timeout, bus4.saturated, bus4.sig_Hz);
        end
        rst_n = 1'b1;
        @(negedge clk_100kHz);
    endtask

    task automatic test_measure(input int unsigned period, input int unsigned exp_hz, input bit exp_sat);
        bit found, busy_low;
        int unsigned s, at;
        int d;
        gen_period = 0;
        repeat (8) @(negedge clk_100kHz);
        gen_period = period;
        repeat (8) @(negedge clk_100kHz);
        pulse_start(1'b0, s);
        wait_rv(1'b0, 4 * period + 100, found, at, busy_low);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL meas_p%0d_valid: got no result_valid expected one within %0d cycles", period, 4 * period + 100);
        end else begin
            checks++;
            if (bus1.sig_Hz !== RES_W'(exp_hz)) begin
                errors++;
                $display("FAIL meas_p%0d_hz: got %0d expected %0d", period, bus1.sig_Hz, exp_hz);
            end
            checks++;
            if (bus1.saturated !== exp_sat || bus1.timeout !== 1'b0) begin
                errors++;
                $display("FAIL meas_p%0d_flags: got sat=%b tmo=%b expected sat=%b tmo=0",
                         period, bus1.saturated, bus1.timeout, exp_sat);
            end
            // Final edge to result_valid, as seen by a consumer on the next posedge: 3 + NUM_W + 1
            d = int'(at) + 1 - int'(NUM_W) - 4 - int'(rise_cyc);
            checks++;
            if (d % int'(period) != 0) begin
                errors++;
                $display("FAIL meas_p%0d_latency: got phase offset %0d expected 0", period, d % int'(period));
            end
            checks++;
            if (busy_low) begin
                errors++;
                $display("FAIL meas_p%0d_busy: got busy=0 during measurement expected 1", period);
            end
            @(negedge clk_100kHz);
            checks++;
            if (bus1.result_valid !== 1'b0 || bus1.busy !== 1'b0) begin
                errors++;
                $display("FAIL meas_p%0d_after: got rv=%b busy=%b expected rv=0 busy=0",
                         period, bus1.result_valid, bus1.busy);
            end
        end
    endtask

    task automatic test_timeout_arm();
        bit found, busy_low;
        int unsigned s, at;
        gen_period = 0;
        repeat (8) @(negedge clk_100kHz);
        pulse_start(1'b0, s);
        wait_rv(1'b0, TMO1 + 20, found, at, busy_low);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL tmo_arm_valid: got no result_valid expected one within %0d cycles", TMO1 + 20);
        end else begin
            checks++;
            if (at - s != TMO1) begin
                errors++;
                $display("FAIL tmo_arm_cycles: got %0d ARM cycles expected %0d", at - s, TMO1);
            end
            checks++;
            if (bus1.sig_Hz !== '0 || bus1.timeout !== 1'b1 || bus1.saturated !== 1'b0) begin
                errors++;
                $display("FAIL tmo_arm_out: got hz=%0d tmo=%b sat=%b expected hz=0 tmo=1 sat=0",
                         bus1.sig_Hz, bus1.timeout, bus1.saturated);
            end
        end
        @(negedge clk_100kHz);
    endtask

    task automatic test_timeout_meas();
        bit found, busy_low;
        int unsigned s, at;
        gen_period = 0;
        repeat (8) @(negedge clk_100kHz);
        gen_period = 2000;
        pulse_start(1'b0, s);
        wait_rv(1'b0, TMO1 + 40, found, at, busy_low);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL tmo_meas_valid: got no result_valid expected one within %0d cycles", TMO1 + 40);
        end else begin
            checks++;
            if (at - s != TMO1 + 2) begin
                errors++;
                $display("FAIL tmo_meas_cycles: got %0d expected %0d", at - s, TMO1 + 2);
            end
            checks++;
            if (bus1.sig_Hz !== '0 || bus1.timeout !== 1'b1 || bus1.saturated !== 1'b0) begin
                errors++;
                $display("FAIL tmo_meas_out: got hz=%0d tmo=%b sat=%b expected hz=0 tmo=1 sat=0",
                         bus1.sig_Hz, bus1.timeout, bus1.saturated);
            end
        end
        gen_period = 0;
        @(negedge clk_100kHz);
    endtask

    task automatic test_periods4();
        bit found, busy_low;
        int unsigned s, at;
        int d;
        gen_period = 0;
        repeat (8) @(negedge clk_100kHz);
        gen_period = 250;
        repeat (8) @(negedge clk_100kHz);
        pulse_start(1'b1, s);
        wait_rv(1'b1, 1500, found, at, busy_low);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL p4_valid: got no result_valid expected one within 1500 cycles");
        end else begin
            checks++;
            if (bus4.sig_Hz !== RES_W'(400) || bus4.saturated !== 1'b0 || bus4.timeout !== 1'b0) begin
                errors++;
                $display("FAIL p4_hz: got hz=%0d sat=%b tmo=%b expected hz=400 sat=0 tmo=0",
                         bus4.sig_Hz, bus4.saturated, bus4.timeout);
            end
            d = int'(at) + 1 - int'(NUM_W) - 4 - int'(rise_cyc);
            checks++;
            if (d % 250 != 0) begin
                errors++;
                $display("FAIL p4_latency: got phase offset %0d expected 0", d % 250);
            end
        end
        @(negedge clk_100kHz);
    endtask

    task automatic test_back_to_back();
        bit f1, f2, bl1, bl2;
        int unsigned s, s2, at1, at2;
        bus1.cont  = 1'b1;
        gen_period = 0;
        repeat (8) @(negedge clk_100kHz);
        gen_period = 200;
        repeat (8) @(negedge clk_100kHz);
        pulse_start(1'b0, s);
        wait_rv(1'b0, 700, f1, at1, bl1);
        checks++;
        if (!f1 || bus1.sig_Hz !== RES_W'(500) || bl1) begin
            errors++;
            $display("FAIL b2b_first: got valid=%b hz=%0d busy_low=%b expected valid=1 hz=500 busy_low=0",
                     f1, bus1.sig_Hz, bl1);
        end
        // Lands in MEAS of the second measurement; must not disturb it
        repeat (200) @(negedge clk_100kHz);
        pulse_start(1'b0, s2);
        wait_rv(1'b0, 700, f2, at2, bl2);
        checks++;
        if (!f2 || bus1.sig_Hz !== RES_W'(500)) begin
            errors++;
            $display("FAIL b2b_second: got valid=%b hz=%0d expected valid=1 hz=500", f2, bus1.sig_Hz);
        end
        checks++;
        if (at2 - at1 != 400) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles expected 400", at2 - at1);
        end
        checks++;
        if (bl2) begin
            errors++;
            $display("FAIL b2b_busy: got busy=0 between results expected 1");
        end
        bus1.cont = 1'b0;
        @(negedge clk_100kHz);
        checks++;
        if (bus1.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: got busy=%b expected 0 after cont dropped", bus1.busy);
        end
    endtask

    task automatic test_reset_mid_div();
        bit f1, bl1, seen;
        int unsigned s, at1;
        bus1.cont  = 1'b1;
        gen_period = 0;
        repeat (8) @(negedge clk_100kHz);
        gen_period = 100;
        repeat (8) @(negedge clk_100kHz);
        pulse_start(1'b0, s);
        wait_rv(1'b0, 500, f1, at1, bl1);
        checks++;
        if (!f1 || bus1.sig_Hz !== RES_W'(1000)) begin
            errors++;
            $display("FAIL rstdiv_pre: got valid=%b hz=%0d expected valid=1 hz=1000", f1, bus1.sig_Hz);
        end
        // Next result lands 200 cycles later; its DIV occupies the 24 cycles before that
        repeat (190) @(negedge clk_100kHz);
        checks++;
        if (bus1.busy !== 1'b1) begin
            errors++;
            $display("FAIL rstdiv_busy: got busy=%b expected 1 before reset", bus1.busy);
        end
        rst_n = 1'b0;
        @(negedge clk_100kHz);
        checks++;
        if ({bus1.busy, bus1.result_valid, bus1.timeout, bus1.saturated, bus1.sig_Hz} !== '0) begin
            errors++;
            $display("FAIL rstdiv_out: got busy=%b rv=%b tmo=%b sat=%b hz=%0d expected all 0",
                     bus1.busy, bus1.result_valid, bus1.timeout, bus1.saturated, bus1.sig_Hz);
        end
        rst_n     = 1'b1;
        bus1.cont = 1'b0;
        seen      = 1'b0;
        for (int unsigned i = 0; i < 60; i++) begin
            @(negedge clk_100kHz);
            if (bus1.result_valid !== 1'b0 || bus1.busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rstdiv_quiet: got activity after reset expected rv=0 busy=0 for 60 cycles");
        end
    endtask

    initial begin
        int unsigned periods [4] = '{100, 3, 7, 6};
        int unsigned exp_hz  [4] = '{1000, 16383, 14285, 16383};
        bit          exp_sat [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        bus1.start = 1'b0;
        bus1.cont  = 1'b0;
        bus4.start = 1'b0;
        bus4.cont  = 1'b0;
        test_reset();
        for (int i = 0; i < 3; i++) test_measure(periods[i], exp_hz[i], exp_sat[i]);
        test_timeout_arm();
        test_measure(periods[3], exp_hz[3], exp_sat[3]);
        test_timeout_meas();
        test_periods4();
        test_back_to_back();
        test_reset_mid_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
